uart_nums: RTL and testbench
============================

Name: uart_nums

Overview:
- Fixed-frame serial link between the FPGA core and an external host/microcontroller; it sends and receives packets of signed 16-bit numbers over 8N1 UART.
- A TX packet is a snapshot of N_TX_NUMS words sent on a one-cycle request.
- An RX packet of N_RX_NUMS words is assembled and presented with a one-cycle valid strobe.
- It sits between the top-level pins (uart_rx/uart_tx) and the vector-processing datapath.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate; bit period BIT_CLKS = CLK_FREQ/BAUD, integer-truncated (434).
- n_tx_nums, 6, number of 16-bit words per transmitted packet (>=1).
- n_rx_nums, 5, number of 16-bit words per received packet (>=1).
- RX_TIMEOUT_BITS, 20, inter-byte gap limit in bit periods; used only with the optional feature.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- rx, input, 1, asynchronous serial input; idle high.
- tx, output, 1, serial output; idle high.
- send_data, input, 1, transmit request; acted on only when tx_ready=1.
- tx_nums, input, n_tx_nums x 16 signed (unpacked array [n_tx_nums-1:0]), words to send.
- tx_ready, output, 1, high when the transmitter is idle.
- rx_available, output, 1, one-cycle strobe: a new packet is on rx_nums.
- rx_nums, output, n_rx_nums x 16 signed (unpacked array [n_rx_nums-1:0]), last complete RX packet.

Behaviour:
- Reset (synchronous, active-high): tx=1, tx_ready=1, rx_available=0, all rx_nums=0.
  - All FSMs return to IDLE and all counters clear.
  - A reset mid-frame aborts the frame immediately; tx returns high on the next cycle.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts BIT_CLKS cycles.
- Word order: element 0 first, ascending index. Within a word, the high byte goes first.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, tx_ready=1.
  - send_data=1 in IDLE: on that edge, latch all tx_nums words into an internal buffer, set byte index to 0 and enter START. tx_ready goes low the following cycle and tx drives 0 the same cycle.
  - After each STOP period, advance the byte index. Go to START if bytes remain (back-to-back frames, no idle gap), else go to IDLE.
  - Total busy time = n_tx_nums*2*10*BIT_CLKS cycles; defaults give 52080 cycles (~1.04 ms).
  - send_data while busy is ignored. Changes to tx_nums after the latch do not affect the packet in flight.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - Start detection: the synchronized line goes low while in IDLE.
  - At BIT_CLKS/2, re-check the start bit; if it is high, abort as a glitch and return to IDLE.
  - Sample each data bit and the stop bit at mid-bit, i.e. every BIT_CLKS from the verified start-bit centre.
  - Stop bit = 0 (framing error): discard the byte, clear the packet byte counter, and return to IDLE once the line is high.
  - Good bytes fill the packet assembly buffer, high byte then low byte per word, word 0 first.
  - When byte 2*n_rx_nums-1 completes: copy the whole buffer to rx_nums on that edge, assert rx_available for exactly one cycle, and clear the byte counter.
  - rx_nums holds its value until the next complete packet; partial packets never alter it.
- TX and RX are fully independent and may run simultaneously.

Optional Feature:
- Macro UART_RX_TIMEOUT_EN.
- When defined: an inter-byte gap timer runs while a packet is partially received. If the line stays idle for more than RX_TIMEOUT_BITS*BIT_CLKS cycles after a stop bit, the partial packet is discarded (byte counter=0) and the next byte is treated as byte 0 of a new packet. rx_nums and rx_available are not affected.
- When undefined: no timer exists, and partial packets wait indefinitely.

Test Plan:
- Reset: hold reset 1 cycle -> tx=1, tx_ready=1, rx_available=0, rx_nums all 0x0000.
- TX packet: tx_nums[0..5]={DABE,00C1,FD3C,FEDA,F6A5,175B}, pulse send_data 1 cycle -> tx_ready=0 next cycle; line bytes DA BE 00 C1 FD 3C FE DA F6 A5 17 5B; each bit 434 cycles; tx_ready=1 after 52080 cycles.
- Loopback: drive rx from a second instance (n_tx_nums=5) sending {0x0001,0xFFFF,0x8000,0x7FFF,0x1234} -> one rx_available pulse; rx_nums equal those values in order, with signedness preserved.
- Busy ignore: pulse send_data again 1000 cycles into a packet with different tx_nums -> no extra bytes; line carries only the original 12 bytes.
- Framing error: send byte 0x12 with stop bit 0, then a full valid 10-byte packet -> no pulse for the bad frame; exactly one rx_available with the valid data.
- Reset mid-RX: assert reset after 3 bytes, then send 10 valid bytes -> rx_available after the 10th byte; rx_nums matches the new packet. With UART_RX_TIMEOUT_EN: send 3 bytes, idle 25 bit periods, then 10 bytes -> one rx_available with correct data.

Source files
------------

// File: rtl/uart_nums_if.sv
// Core-side bundle of the uart_nums link: transmit request/data and receive data/strobe.
// slave  : the UART block (samples send_data/tx_nums, drives tx_ready/rx_available/rx_nums).
// master : the datapath side (drives send_data/tx_nums, observes the rest).
interface uart_nums_if #(
    parameter int n_tx_nums = 6,
    parameter int n_rx_nums = 5
);
    logic               send_data;
    logic signed [15:0] tx_nums [n_tx_nums-1:0];
    logic               tx_ready;
    logic               rx_available;
    logic signed [15:0] rx_nums [n_rx_nums-1:0];

    modport master (
        output send_data,
        output tx_nums,
        input  tx_ready,
        input  rx_available,
        input  rx_nums
    );

    modport slave (
        input  send_data,
        input  tx_nums,
        output tx_ready,
        output rx_available,
        output rx_nums
    );
endinterface

// File: rtl/uart_nums.sv
// Packetised 8N1 UART: sends n_tx_nums signed 16-bit words, receives n_rx_nums words.
// Latency: TX line goes low the cycle after send_data; rx_available pulses at the stop-bit centre of the last byte.
// Backpressure: send_data is ignored while tx_ready=0; received packets are never stalled (rx_nums is overwritten).
// Ports: clk, reset (sync, active-high), rx (async serial in), tx (serial out),
//        bus (uart_nums_if.slave: send_data, tx_nums, tx_ready, rx_available, rx_nums).
// Optional: define UART_RX_TIMEOUT_EN to drop a partial RX packet after an idle gap
//           of more than RX_TIMEOUT_BITS bit periods.
module uart_nums #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int BAUD            = 115200,
    parameter int n_tx_nums       = 6,
    parameter int n_rx_nums       = 5,
    parameter int RX_TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    uart_nums_if.slave bus
);
    localparam int BIT_CLKS  = CLK_FREQ / BAUD;
    localparam int HALF_CLKS = (BIT_CLKS / 2 > 0) ? BIT_CLKS / 2 : 1;
    localparam int CNT_W     = $clog2(BIT_CLKS + 1);
    localparam int TX_BYTES  = 2 * n_tx_nums;
    localparam int RX_BYTES  = 2 * n_rx_nums;
    localparam int TXI_W     = $clog2(TX_BYTES);
    localparam int RXI_W     = $clog2(RX_BYTES);
    localparam int TX_W      = 16 * n_tx_nums;
    localparam int RX_W      = 16 * n_rx_nums;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);
    localparam logic [TXI_W-1:0] TX_LAST   = TXI_W'(TX_BYTES - 1);
    localparam logic [RXI_W-1:0] RX_LAST   = RXI_W'(RX_BYTES - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [TXI_W-1:0] tx_idx_q, tx_idx_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    // Whole packet as one shift register, next byte to send always in the top 8 bits.
    logic [TX_W-1:0]  tx_pkt_q, tx_pkt_d;
    logic             tx_q, tx_d;
    logic             tx_bit_end;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_pkt_d   = tx_pkt_q;
        tx_d       = tx_q;
        tx_bit_end = (tx_cnt_q == BIT_LAST);

        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CNT_W'(1);
        end

        unique case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (bus.send_data) begin
                    // Word 0 lands in the top bits so it is shifted out first, high byte first.
                    for (int i = 0; i < n_tx_nums; i++) begin
                        tx_pkt_d[(n_tx_nums-1-i)*16 +: 16] = bus.tx_nums[i];
                    end
                    tx_idx_d   = '0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_pkt_q[TX_W-8];
                    tx_shift_d = {1'b0, tx_pkt_q[TX_W-1 -: 7]};
                    tx_pkt_d   = tx_pkt_q << 8;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == TX_LAST) begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                    end else begin
                        // Next frame starts immediately, no idle gap between bytes.
                        tx_idx_d   = tx_idx_q + TXI_W'(1);
                        tx_state_d = TX_START;
                        tx_d       = 1'b0;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_pkt_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_pkt_q   <= tx_pkt_d;
            tx_q       <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign bus.tx_ready = (tx_state_q == TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic               rx_s1_q, rx_s2_q;
    rx_state_t          rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [RXI_W-1:0]   rx_idx_q, rx_idx_d;
    // Holds all bytes but the last; the final byte is taken straight from rx_shift_q.
    logic [RX_W-9:0]    rx_pkt_q, rx_pkt_d;
    logic [RX_W-1:0]    rx_full;
    logic               rx_avail_q, rx_avail_d;
    logic signed [15:0] rx_nums_q [n_rx_nums-1:0];
    logic signed [15:0] rx_nums_d [n_rx_nums-1:0];
    logic               rx_bit_end;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_CLKS = RX_TIMEOUT_BITS * BIT_CLKS;
    localparam int TO_W    = $clog2(TO_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CLKS);
    logic [TO_W-1:0] gap_q, gap_d;
`else
    // Without the timer a partial packet waits indefinitely for its remaining bytes.
    logic unused_timeout_bits;
    assign unused_timeout_bits = ^RX_TIMEOUT_BITS;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_idx_d   = rx_idx_q;
        rx_pkt_d   = rx_pkt_q;
        rx_avail_d = 1'b0;
        rx_nums_d  = rx_nums_q;
        rx_full    = {rx_pkt_q, rx_shift_q};
        rx_bit_end = (rx_cnt_q == BIT_LAST);

        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Re-check at the start-bit centre; a high line here was a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + CNT_W'(1);
                if (rx_bit_end) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + CNT_W'(1);
                if (rx_bit_end) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                        if (rx_idx_q == RX_LAST) begin
                            rx_idx_d   = '0;
                            rx_avail_d = 1'b1;
                            for (int i = 0; i < n_rx_nums; i++) begin
                                rx_nums_d[i] = rx_full[(n_rx_nums-1-i)*16 +: 16];
                            end
                        end else begin
                            rx_idx_d = rx_idx_q + RXI_W'(1);
                            rx_pkt_d = (rx_pkt_q << 8) | (RX_W-8)'(rx_shift_q);
                        end
                    end else begin
                        // Framing error: drop the byte and the packet built so far.
                        rx_idx_d   = '0;
                        rx_state_d = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

`ifdef UART_RX_TIMEOUT_EN
        // Gap timer runs only while idle with a partial packet pending.
        gap_d = '0;
        if (rx_state_q == RX_IDLE && rx_s2_q && rx_idx_q != '0) begin
            if (gap_q == TO_LAST) begin
                rx_idx_d = '0;
            end else begin
                gap_d = gap_q + TO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_idx_q   <= '0;
            rx_pkt_q   <= '0;
            rx_avail_q <= 1'b0;
            for (int i = 0; i < n_rx_nums; i++) begin
                rx_nums_q[i] <= '0;
            end
`ifdef UART_RX_TIMEOUT_EN
            gap_q      <= '0;
`endif
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_idx_q   <= rx_idx_d;
            rx_pkt_q   <= rx_pkt_d;
            rx_avail_q <= rx_avail_d;
            for (int i = 0; i < n_rx_nums; i++) begin
                rx_nums_q[i] <= rx_nums_d[i];
            end
`ifdef UART_RX_TIMEOUT_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign bus.rx_available = rx_avail_q;
    assign bus.rx_nums      = rx_nums_q;

endmodule

// File: tb/tb_uart_nums.sv
// Directed bench for uart_nums: reset state, TX packet bytes/timing, busy-ignore,
// loopback from a second instance, table of RX packets, framing error and reset mid-RX.
module tb_uart_nums;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int B        = CLK_FREQ / BAUD;   // 16 clocks per bit
    localparam int NTX      = 6;
    localparam int NRX      = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic rx_drv   = 1'b1;
    logic loop_sel = 1'b0;
    logic src_rx   = 1'b1;
    logic rx_line, tx_line, src_tx;
    assign rx_line = loop_sel ? src_tx : rx_drv;

    uart_nums_if #(.n_tx_nums(NTX), .n_rx_nums(NRX)) bus ();
    uart_nums_if #(.n_tx_nums(5),   .n_rx_nums(NRX)) bus2 ();

    uart_nums #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .n_tx_nums(NTX), .n_rx_nums(NRX), .RX_TIMEOUT_BITS(20)) dut (
        .clk(clk), .reset(reset), .rx(rx_line), .tx(tx_line), .bus(bus.slave)
    );

    uart_nums #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .n_tx_nums(5), .n_rx_nums(NRX), .RX_TIMEOUT_BITS(20)) u_src (
        .clk(clk), .reset(reset), .rx(src_rx), .tx(src_tx), .bus(bus2.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Count cycles in which rx_available is high.
    int avail_cnt = 0;
    always @(negedge clk) if (bus.rx_available === 1'b1) avail_cnt++;

    // Line monitor decoding the DUT's tx pin at mid-bit.
    logic       mon_en = 1'b0;
    logic [7:0] mon_q[$];
    logic [7:0] mon_b;
    int         mon_stop_err = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx_line === 1'b0) begin
                repeat (B / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (B) @(negedge clk);
                    mon_b[j] = tx_line;
                end
                repeat (B) @(negedge clk);
                if (tx_line !== 1'b1) mon_stop_err++;
                mon_q.push_back(mon_b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rx_drv = 1'b0;
        repeat (B) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            rx_drv = b[j];
            repeat (B) @(negedge clk);
        end
        rx_drv = stop_val;
        repeat (B) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  bytes [10];
        logic [15:0] words [5];
    } rx_vec_t;

    rx_vec_t     vecs [3];
    logic [15:0] tx_words   [6];
    logic [7:0]  exp_tx     [12];
    logic [15:0] loop_words [5];
    int          cyc;
    int          a0;

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h01};
        vecs[0].words = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h8001};
        vecs[1].bytes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h55, 8'hAA, 8'h7F, 8'h80, 8'hFE, 8'hDC};
        vecs[1].words = '{16'h0001, 16'h0203, 16'h55AA, 16'h7F80, 16'hFEDC};
        vecs[2].bytes = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h69, 8'hE1, 8'h1E};
        vecs[2].words = '{16'hA55A, 16'hC33C, 16'h0FF0, 16'h9669, 16'hE11E};
        tx_words   = '{16'hDABE, 16'h00C1, 16'hFD3C, 16'hFEDA, 16'hF6A5, 16'h175B};
        exp_tx     = '{8'hDA, 8'hBE, 8'h00, 8'hC1, 8'hFD, 8'h3C, 8'hFE, 8'hDA, 8'hF6, 8'hA5, 8'h17, 8'h5B};
        loop_words = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234};

        bus.send_data  = 1'b0;
        bus2.send_data = 1'b0;
        for (int i = 0; i < NTX; i++) bus.tx_nums[i] = '0;
        for (int i = 0; i < 5; i++) bus2.tx_nums[i] = '0;

        // Reset held for one edge.
        @(negedge clk);
        check("rst_tx", {15'd0, tx_line}, 16'd1);
        check("rst_tx_ready", {15'd0, bus.tx_ready}, 16'd1);
        check("rst_rx_available", {15'd0, bus.rx_available}, 16'd0);
        for (int k = 0; k < NRX; k++) check($sformatf("rst_rx_nums%0d", k), bus.rx_nums[k], 16'h0000);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // TX packet, with a second request and new data 1000 cycles in.
        mon_en = 1'b1;
        for (int i = 0; i < NTX; i++) bus.tx_nums[i] = tx_words[i];
        bus.send_data = 1'b1;
        @(negedge clk);
        bus.send_data = 1'b0;
        check("tx_ready_drop", {15'd0, bus.tx_ready}, 16'd0);
        check("tx_start_low", {15'd0, tx_line}, 16'd0);
        cyc = 0;
        while (bus.tx_ready !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            bus.send_data = (cyc == 1000);
            if (cyc == 1000) for (int i = 0; i < NTX; i++) bus.tx_nums[i] = 16'h5A5A ^ 16'(i);
        end
        bus.send_data = 1'b0;
        check("tx_busy_cycles", 16'(cyc), 16'(NTX * 20 * B));
        repeat (40 * B) @(negedge clk);
        check("tx_byte_count", 16'(mon_q.size()), 16'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("tx_byte%0d", i), (i < mon_q.size()) ? {8'd0, mon_q[i]} : 16'hxxxx, {8'd0, exp_tx[i]});
        check("tx_stop_bits", 16'(mon_stop_err), 16'd0);
        check("tx_idle_after", {15'd0, bus.tx_ready}, 16'd1);

        // Loopback from the 5-word instance.
        for (int i = 0; i < 5; i++) bus2.tx_nums[i] = loop_words[i];
        loop_sel = 1'b1;
        a0 = avail_cnt;
        bus2.send_data = 1'b1;
        @(negedge clk);
        bus2.send_data = 1'b0;
        cyc = 0;
        while (bus2.tx_ready !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2 * B) @(negedge clk);
        loop_sel = 1'b0;
        check("loop_avail_pulses", 16'(avail_cnt - a0), 16'd1);
        for (int k = 0; k < NRX; k++) check($sformatf("loop_w%0d", k), bus.rx_nums[k], loop_words[k]);
        check("loop_signed_neg", (bus.rx_nums[2] < 0) ? 16'd1 : 16'd0, 16'd1);
        check("loop_signed_pos", (bus.rx_nums[3] > 0) ? 16'd1 : 16'd0, 16'd1);

        // Table of received packets.
        for (int v = 0; v < 3; v++) begin
            a0 = avail_cnt;
            for (int b = 0; b < 10; b++) send_byte(vecs[v].bytes[b], 1'b1);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_pulses", v), 16'(avail_cnt - a0), 16'd1);
            for (int k = 0; k < NRX; k++)
                check($sformatf("vec%0d_w%0d", v, k), bus.rx_nums[k], vecs[v].words[k]);
        end

        // Framing error, then a good packet.
        a0 = avail_cnt;
        send_byte(8'h12, 1'b0);
        repeat (2 * B) @(negedge clk);
        check("frm_no_pulse", 16'(avail_cnt - a0), 16'd0);
        check("frm_hold_w4", bus.rx_nums[4], 16'hE11E);
        for (int b = 0; b < 10; b++) send_byte(vecs[0].bytes[b], 1'b1);
        repeat (2) @(negedge clk);
        check("frm_pulses", 16'(avail_cnt - a0), 16'd1);
        for (int k = 0; k < NRX; k++) check($sformatf("frm_w%0d", k), bus.rx_nums[k], vecs[0].words[k]);

        // Reset after 3 bytes, then a full packet.
        for (int b = 0; b < 3; b++) send_byte(vecs[1].bytes[b], 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstrx_nums_clear", bus.rx_nums[0], 16'h0000);
        a0 = avail_cnt;
        for (int b = 0; b < 9; b++) send_byte(vecs[2].bytes[b], 1'b1);
        check("rstrx_no_early", 16'(avail_cnt - a0), 16'd0);
        send_byte(vecs[2].bytes[9], 1'b1);
        repeat (2) @(negedge clk);
        check("rstrx_pulses", 16'(avail_cnt - a0), 16'd1);
        for (int k = 0; k < NRX; k++) check($sformatf("rstrx_w%0d", k), bus.rx_nums[k], vecs[2].words[k]);

`ifdef UART_RX_TIMEOUT_EN
        // Partial packet abandoned by a long idle gap.
        a0 = avail_cnt;
        for (int b = 0; b < 3; b++) send_byte(vecs[0].bytes[b], 1'b1);
        repeat (25 * B) @(negedge clk);
        for (int b = 0; b < 10; b++) send_byte(vecs[1].bytes[b], 1'b1);
        repeat (2) @(negedge clk);
        check("to_pulses", 16'(avail_cnt - a0), 16'd1);
        for (int k = 0; k < NRX; k++) check($sformatf("to_w%0d", k), bus.rx_nums[k], vecs[1].words[k]);
`endif

        // Reset in the middle of a TX frame.
        mon_en = 1'b0;
        for (int i = 0; i < NTX; i++) bus.tx_nums[i] = '0;
        bus.send_data = 1'b1;
        @(negedge clk);
        bus.send_data = 1'b0;
        repeat (5 * B) @(negedge clk);
        check("txrst_mid_low", {15'd0, tx_line}, 16'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("txrst_tx_high", {15'd0, tx_line}, 16'd1);
        check("txrst_ready", {15'd0, bus.tx_ready}, 16'd1);
        repeat (2 * B) @(negedge clk);
        check("txrst_stays_high", {15'd0, tx_line}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
